tone_arbiter: RTL and testbench
===============================

# tone_arbiter

Shares the single tone path (note select → FREQ mux and seven-segment display) among four note sources: demo autoplay, lesson, free play and a spare port. It uses fixed-priority arbitration with preemption. Between any two granted notes it inserts a short silent articulation gap. A hold timeout stops one source from monopolising the tone path while others wait. It sits between the note sources and the FREQ select logic in `piano`, and replaces the combinational mode-based note mux.

## Interface
Parameters:
- GAP_CYCLES, 1000: silent CLK cycles between consecutive grants; 0 is treated as 1.
- MAX_HOLD, 16: QUARTER_BEAT ticks an owner may hold the grant while another source requests; 0 disables the timeout; range 0–255.

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous, active-low reset.
- QUARTER_BEAT  input  1  one-CLK pulse per quarter beat, from clockManager.
- REQ  input  4  request per source; bit 0 has highest priority, bit 3 lowest.
- NOTE0..NOTE3  input  4 each  note code per source, using the parameters.v constants C4..C5; any other code is REST.
- GRANT  output  4  one-hot owner, or all zero.
- NOTE_OUT  output  4  registered note of the owner.
- TONE_EN  output  1  gates FREQ; high only while in PLAY with a non-REST NOTE_OUT.
- TIMEOUT  output  1  one-cycle pulse when a hold timeout forces a release.

## Operation
- States: IDLE, PLAY, GAP.
- Reset values: IDLE, GRANT=0, NOTE_OUT=4'hF (REST), TONE_EN=0, TIMEOUT=0, all counters 0, exclusion mask 0.
- IDLE:
  - If REQ≠0, grant the lowest-index set bit, load NOTE_OUT from that source, and go to PLAY.
  - Otherwise stay in IDLE.
- PLAY: NOTE_OUT holds the note latched at grant. Exit conditions, in priority order:
  1. Owner's REQ falls → GAP.
  2. A higher-priority REQ bit is set → GAP (preemption).
  3. Owner's NOTE differs from NOTE_OUT → GAP (retrigger articulation).
  4. Hold timeout → GAP. Pulse TIMEOUT and set the exclusion mask to the owner bit.
- If the owner's note is REST while REQ is held, stay in PLAY with TONE_EN=0. A change from REST to a note is still a retrigger.
- Hold counter:
  - 8-bit, cleared on entry to PLAY.
  - Increments on QUARTER_BEAT while in PLAY and saturates at 255.
  - Timeout fires when the counter equals MAX_HOLD, MAX_HOLD≠0, and (REQ & ~owner)≠0.
  - With no other requester the owner holds indefinitely.
- GAP:
  - GRANT=0, TONE_EN=0, NOTE_OUT unchanged.
  - Lasts max(GAP_CYCLES,1) cycles; the gap counter width is $clog2(GAP_CYCLES+2).
  - On expiry, arbitrate over REQ & ~mask, then clear the mask.
  - If the masked set is empty but REQ≠0, arbitrate over REQ (the excluded source may regain the grant).
  - If REQ=0, go to IDLE.
- Requests that change during GAP are evaluated only at expiry. GAP cannot be preempted.
- At most one GRANT bit is ever set.

## Timing
- REQ, NOTEx and QUARTER_BEAT are sampled on the CLK rising edge. All outputs are registered.
- IDLE→PLAY: REQ high at edge n gives GRANT, NOTE_OUT and TONE_EN valid after edge n+1 (one-cycle latency).
- PLAY exit: the condition seen at edge n drops GRANT and TONE_EN after edge n+1. TIMEOUT is high for that one cycle.
- GAP of G cycles: the next GRANT appears G+1 cycles after the exit edge.
- Simultaneous events: owner drop together with a higher-priority request, or a retrigger together with a timeout, produce a single GAP. TIMEOUT pulses only when condition 4 is the selecting cause.
- RESET_N low mid-operation forces reset values immediately, independent of CLK. The first grant can occur on the first edge after release.
- Inputs are synchronous to CLK; switch debouncing happens upstream.

## Test plan
- Reset and basic grant: hold RESET_N low then release; REQ=4'b0100, NOTE2=E → after 1 cycle GRANT=4'b0100, NOTE_OUT=E, TONE_EN=1. Drop REQ → GAP of GAP_CYCLES cycles → IDLE with GRANT=0.
- Preemption: source 2 playing G; assert REQ[0] with NOTE0=C4 → GRANT=0 for GAP_CYCLES cycles → GRANT=4'b0001, NOTE_OUT=C4. Source 2 does not regain the grant while REQ[0] stays high.
- Retrigger: owner source 1 changes NOTE1 from A to B → GAP of exactly GAP_CYCLES cycles with TONE_EN=0 → GRANT=4'b0010, NOTE_OUT=B. A REST code with REQ held → TONE_EN=0, GRANT unchanged.
- Timeout: MAX_HOLD=2; source 0 holds C5 with REQ[3] pending → on the 2nd QUARTER_BEAT TIMEOUT pulses once → after the gap GRANT=4'b1000. With REQ[3] low the owner holds past 10 beats and TIMEOUT never fires.
- Boundaries: GAP_CYCLES=0 gives a 1-cycle gap. The hold counter saturates at 255 with MAX_HOLD=0. The only requester is the excluded one after a timeout → it is regranted. Owner drop plus higher request in the same cycle → one GAP, TIMEOUT=0.
- Async reset mid-PLAY: assert RESET_N low between edges → GRANT=0, NOTE_OUT=4'hF, TONE_EN=0 immediately, before the next edge.

Source files
------------

// File: rtl/tone_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tone_arbiter
// Purpose  : Fixed-priority, preemptive owner selection for the shared tone path,
//            with a silent articulation gap between grants and a hold timeout.
// Revision : 1.0  initial release
// =============================================================================

module tone_arbiter #(
   parameter int GAP_CYCLES = 1000,
   parameter int MAX_HOLD   = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       QUARTER_BEAT,
   input  logic [3:0] REQ,
   input  logic [3:0] NOTE0,
   input  logic [3:0] NOTE1,
   input  logic [3:0] NOTE2,
   input  logic [3:0] NOTE3,
   output logic [3:0] GRANT,
   output logic [3:0] NOTE_OUT,
   output logic       TONE_EN,
   output logic       TIMEOUT
);

   localparam int             GAP_EFF    = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
   localparam int             GCW        = $clog2(GAP_CYCLES + 2);
   localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP_EFF - 1);
   localparam logic [7:0]     HOLD_LIMIT = 8'(MAX_HOLD);
   localparam logic           HOLD_EN    = (MAX_HOLD != 0);
   localparam logic [3:0]     REST       = 4'hF;
   localparam logic [3:0]     NOTE_TOP   = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [3:0]       note_q, note_d;
   logic             tone_q, tone_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       hold_q, hold_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic [3:0]       mask_q, mask_d;

   logic [3:0]       w_src_note [4];
   logic [3:0]       w_masked;
   logic [3:0]       w_arb_set;
   logic [3:0]       w_win;
   logic [3:0]       w_win_note;
   logic [3:0]       w_owner_note;
   logic [3:0]       w_higher;
   logic             w_leave;
   logic             w_timeout_hit;

   // Codes outside C4..C5 all collapse to REST so comparisons see one rest value.
   function automatic logic [3:0] norm_note(input logic [3:0] n);
      return (n <= NOTE_TOP) ? n : REST;
   endfunction

   assign w_src_note[0] = norm_note(NOTE0);
   assign w_src_note[1] = norm_note(NOTE1);
   assign w_src_note[2] = norm_note(NOTE2);
   assign w_src_note[3] = norm_note(NOTE3);

   assign w_masked = REQ & ~mask_q;

   always_comb begin
      w_arb_set = 4'd0;
      if (state_q == S_IDLE) begin
         w_arb_set = REQ;
      end else if (state_q == S_GAP) begin
         w_arb_set = (w_masked != 4'd0) ? w_masked : REQ;
      end
   end

   assign w_win = w_arb_set & (~w_arb_set + 4'd1);

   always_comb begin
      w_win_note   = REST;
      w_owner_note = REST;
      for (int i = 0; i < 4; i++) begin
         if (w_win[i]) begin
            w_win_note = w_src_note[i];
         end
         if (grant_q[i]) begin
            w_owner_note = w_src_note[i];
         end
      end
   end

   // For a one-hot owner, (owner - 1) covers exactly the higher-priority bits.
   assign w_higher      = REQ & (grant_q - 4'd1);
   assign w_leave       = ((REQ & grant_q) == 4'd0) || (w_higher != 4'd0) ||
                          (w_owner_note != note_q);
   assign w_timeout_hit = HOLD_EN && (hold_q == HOLD_LIMIT) &&
                          ((REQ & ~grant_q) != 4'd0);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      note_d    = note_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      gap_d     = gap_q;
      mask_d    = mask_q;
      case (state_q)
         S_IDLE: begin
            if (w_win != 4'd0) begin
               state_d = S_PLAY;
               grant_d = w_win;
               note_d  = w_win_note;
               hold_d  = 8'd0;
            end
         end
         S_PLAY: begin
            if (w_leave || w_timeout_hit) begin
               state_d = S_GAP;
               grant_d = 4'd0;
               gap_d   = '0;
               if (!w_leave) begin
                  timeout_d = 1'b1;
                  mask_d    = grant_q;
               end
            end else if (QUARTER_BEAT && (hold_q != 8'hFF)) begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               mask_d = 4'd0;
               if (w_win != 4'd0) begin
                  state_d = S_PLAY;
                  grant_d = w_win;
                  note_d  = w_win_note;
                  hold_d  = 8'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q + GCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 4'd0;
         end
      endcase
      tone_d = (state_d == S_PLAY) && (note_d != REST);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         grant_q   <= 4'd0;
         note_q    <= REST;
         tone_q    <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= 8'd0;
         gap_q     <= '0;
         mask_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         note_q    <= note_d;
         tone_q    <= tone_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         mask_q    <= mask_d;
      end
   end

   assign GRANT    = grant_q;
   assign NOTE_OUT = note_q;
   assign TONE_EN  = tone_q;
   assign TIMEOUT  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Two arbiter configurations driven by shared directed and random stimulus,
// each compared every cycle against a behavioural model of the arbitration rules.

module tb_tone_arbiter;

   localparam int NDUT    = 2;
   localparam int GAP_P0  = 3;
   localparam int HOLD_P0 = 2;
   localparam int GAP_P1  = 0;
   localparam int HOLD_P1 = 0;

   int gap_cfg  [NDUT] = '{GAP_P0, GAP_P1};
   int hold_cfg [NDUT] = '{HOLD_P0, HOLD_P1};

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       qb    = 1'b0;
   logic [3:0] req   = 4'd0;
   logic [3:0] note [4];

   logic [3:0] gnt  [NDUT];
   logic [3:0] nout [NDUT];
   logic       ten  [NDUT];
   logic       tmo  [NDUT];

   int errors  = 0;
   int checks  = 0;
   int tmo_cnt = 0;

   int m_st   [NDUT];   // 0 idle, 1 playing, 2 silent gap
   int m_own  [NDUT];
   int m_note [NDUT];
   int m_hold [NDUT];
   int m_left [NDUT];
   int m_excl [NDUT];
   bit m_to   [NDUT];

   tone_arbiter #(.GAP_CYCLES(GAP_P0), .MAX_HOLD(HOLD_P0)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .QUARTER_BEAT(qb), .REQ(req),
      .NOTE0(note[0]), .NOTE1(note[1]), .NOTE2(note[2]), .NOTE3(note[3]),
      .GRANT(gnt[0]), .NOTE_OUT(nout[0]), .TONE_EN(ten[0]), .TIMEOUT(tmo[0])
   );

   tone_arbiter #(.GAP_CYCLES(GAP_P1), .MAX_HOLD(HOLD_P1)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .QUARTER_BEAT(qb), .REQ(req),
      .NOTE0(note[0]), .NOTE1(note[1]), .NOTE2(note[2]), .NOTE3(note[3]),
      .GRANT(gnt[1]), .NOTE_OUT(nout[1]), .TONE_EN(ten[1]), .TIMEOUT(tmo[1])
   );

   always #5 clk = ~clk;

   function automatic int norm(input logic [3:0] n);
      return (n <= 4'd7) ? int'(n) : 15;
   endfunction

   function automatic int first_req(input logic [3:0] r, input int skip);
      for (int i = 0; i < 4; i++) begin
         if (r[i] && (i != skip)) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_st[k] = 0; m_own[k] = -1; m_note[k] = 15; m_hold[k] = 0;
         m_left[k] = 0; m_excl[k] = -1; m_to[k] = 1'b0;
      end
   endtask

   task automatic m_grant(input int k, input int i);
      m_st[k] = 1; m_own[k] = i; m_note[k] = norm(note[i]); m_hold[k] = 0;
   endtask

   task automatic m_gap(input int k);
      m_st[k] = 2; m_own[k] = -1;
      m_left[k] = (gap_cfg[k] < 1) ? 1 : gap_cfg[k];
   endtask

   task automatic m_step(input int k);
      int  o;
      int  w;
      bit  higher;
      bit  others;
      m_to[k] = 1'b0;
      case (m_st[k])
         0: if (req != 4'd0) m_grant(k, first_req(req, -1));
         1: begin
            o = m_own[k];
            higher = 1'b0;
            others = 1'b0;
            for (int j = 0; j < 4; j++) begin
               if (req[j] && j < o) higher = 1'b1;
               if (req[j] && j != o) others = 1'b1;
            end
            if (!req[o] || higher || norm(note[o]) != m_note[k]) begin
               m_gap(k);
            end else if (hold_cfg[k] != 0 && m_hold[k] == hold_cfg[k] && others) begin
               m_gap(k); m_to[k] = 1'b1; m_excl[k] = o;
            end else if (qb && m_hold[k] < 255) begin
               m_hold[k]++;
            end
         end
         default: begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               w = first_req(req, m_excl[k]);
               if (w < 0) w = first_req(req, -1);
               m_excl[k] = -1;
               if (w >= 0) m_grant(k, w);
               else m_st[k] = 0;
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      logic [3:0] eg;
      for (int k = 0; k < NDUT; k++) begin
         eg = (m_st[k] == 1) ? 4'(1 << m_own[k]) : 4'd0;
         chk($sformatf("%s.%0d.grant", ph, k), gnt[k], eg);
         chk($sformatf("%s.%0d.note", ph, k), nout[k], 4'(m_note[k]));
         chk($sformatf("%s.%0d.tone", ph, k), {3'd0, ten[k]},
             {3'd0, (m_st[k] == 1 && m_note[k] != 15)});
         chk($sformatf("%s.%0d.timeout", ph, k), {3'd0, tmo[k]}, {3'd0, m_to[k]});
      end
   endtask

   task automatic tick(input string ph);
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < NDUT; k++) m_step(k);
      end else begin
         m_reset();
      end
      #1;
      check_all(ph);
      if (tmo[0]) tmo_cnt++;
   endtask

   task automatic run(input int n, input int qbe, input string ph);
      for (int i = 0; i < n; i++) begin
         qb = (qbe > 0) && ((i % qbe) == (qbe - 1));
         tick(ph);
      end
      qb = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) note[i] = 4'hF;
      m_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant", gnt[0], 4'd0);
      chk("rst_note", nout[0], 4'hF);
      chk("rst_tone", {3'd0, ten[0]}, 4'd0);
      chk("rst_timeout", {3'd0, tmo[1]}, 4'd0);
      run(3, 0, "reset");
      rst_n = 1'b1;

      // basic grant, release and return to idle
      req = 4'b0100; note[2] = 4'd2;
      tick("basic");
      chk("basic_grant", gnt[0], 4'b0100);
      chk("basic_note", nout[0], 4'd2);
      chk("basic_tone", {3'd0, ten[0]}, 4'd1);
      run(3, 0, "basic");
      req = 4'd0;
      run(GAP_P0, 0, "basic_gap");
      chk("basic_idle", gnt[0], 4'd0);

      // preemption by source 0
      req = 4'b0100; note[2] = 4'd4;
      run(3, 0, "pre_play");
      req = 4'b0101; note[0] = 4'd0;
      tick("pre_exit");
      chk("pre_gap", gnt[0], 4'd0);
      run(GAP_P0, 0, "pre_gap");
      chk("pre_grant", gnt[0], 4'b0001);
      chk("pre_note", nout[0], 4'd0);
      run(6, 0, "pre_hold");

      // retrigger and REST handling on source 1
      req = 4'b0010; note[1] = 4'd5;
      run(GAP_P0 + 3, 0, "retrig_a");
      chk("retrig_grant_a", gnt[0], 4'b0010);
      chk("retrig_note_a", nout[0], 4'd5);
      note[1] = 4'd6;
      tick("retrig_exit");
      chk("retrig_silent", {3'd0, ten[0]}, 4'd0);
      run(GAP_P0, 0, "retrig_gap");
      chk("retrig_grant_b", gnt[0], 4'b0010);
      chk("retrig_note_b", nout[0], 4'd6);
      note[1] = 4'hC;
      run(GAP_P0 + 2, 0, "rest");
      chk("rest_grant", gnt[0], 4'b0010);
      chk("rest_tone", {3'd0, ten[0]}, 4'd0);

      // hold timeout with source 3 waiting
      req = 4'd0;
      run(GAP_P0 + 2, 0, "to_idle");
      tmo_cnt = 0;
      req = 4'b1001; note[0] = 4'd7; note[3] = 4'd1;
      run(8, 3, "timeout");
      chk("timeout_once", 4'(tmo_cnt), 4'd1);
      run(2, 0, "to_gap");
      chk("timeout_next", gnt[0], 4'b1000);

      // excluded source is the only requester at gap expiry
      req = 4'd0;
      run(GAP_P0 + 2, 0, "excl_idle");
      req = 4'b0011; note[1] = 4'd3;
      run(7, 3, "excl_hold");
      req = 4'b0001;
      run(GAP_P0, 0, "excl_gap");
      chk("excl_regrant", gnt[0], 4'b0001);

      // lone owner holds indefinitely; hold counter must not wrap
      tmo_cnt = 0;
      run(40, 3, "hold_alone");
      run(300, 1, "saturate");
      req = 4'b0011;
      run(20, 1, "sat_other");
      chk("sat_no_timeout", 4'(tmo_cnt), 4'd0);
      chk("sat_grant", gnt[0], 4'b0001);

      // owner drop coinciding with a higher request
      req = 4'd0;
      run(GAP_P0 + 2, 0, "drop_idle");
      req = 4'b0100; note[2] = 4'd3;
      run(3, 0, "drop_play");
      req = 4'b0001; note[0] = 4'd0;
      tick("drop_exit");
      chk("drop_gap", gnt[0], 4'd0);
      chk("drop_no_timeout", {3'd0, tmo[0]}, 4'd0);
      tick("drop_gap");
      chk("gap0_regrant", gnt[1], 4'b0001);
      run(GAP_P0 - 1, 0, "drop_gap");
      chk("drop_grant", gnt[0], 4'b0001);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      chk("arst_grant", gnt[0], 4'd0);
      chk("arst_note", nout[0], 4'hF);
      chk("arst_tone", {3'd0, ten[0]}, 4'd0);
      chk("arst_grant1", gnt[1], 4'd0);
      m_reset();
      tick("arst");
      rst_n = 1'b1;
      run(5, 0, "arst_resume");

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5) == 0) req = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(9) == 0) note[i] = 4'($urandom);
         end
         qb = ($urandom_range(3) == 0);
         tick("rand");
      end
      qb = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
